// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: turns a registered-read FIFO (r_en/empty, data one cycle later) into a valid/ready stream
// through a 2-entry prefetch buffer; FIFO_RD_STREAM_STATS_EN adds the beat_cnt counter.
module fifo_rd_stream #(
    parameter int DATA_W = 32
) (
    input  logic              r_clk,
    input  logic              r_rst,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_rd_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data
`ifdef FIFO_RD_STREAM_STATS_EN
    ,
    output logic [31:0]       beat_cnt
`endif
);
    logic [DATA_W-1:0] r_buf [2];
    logic              r_head;
    logic              r_tail;
    logic [1:0]        r_count;
    logic              r_inflight;
    logic              w_pop;
    logic [2:0]        w_level;
    assign m_valid = r_count != 2'd0;
    assign m_data  = r_buf[r_head];
    assign w_pop   = m_valid && m_ready;
    // Occupancy after this edge if no new read is issued; a read is only safe while it stays <= 1.
    assign w_level    = {1'b0, r_count} + {2'b0, r_inflight} - {2'b0, w_pop};
    assign fifo_rd_en = !r_rst && !fifo_empty && (w_level <= 3'd1);
    always_ff @(posedge r_clk or posedge r_rst) begin
        if (r_rst) begin
            r_buf[0]   <= '0;
            r_buf[1]   <= '0;
            r_head     <= 1'b0;
            r_tail     <= 1'b0;
            r_count    <= 2'd0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= fifo_rd_en;
            if (r_inflight) begin
                r_buf[r_tail] <= fifo_rd_data;
                r_tail        <= ~r_tail;
            end
            if (w_pop)
                r_head <= ~r_head;
            r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
        end
    end
`ifdef FIFO_RD_STREAM_STATS_EN
    logic [31:0] r_beat_cnt;
    assign beat_cnt = r_beat_cnt;
    always_ff @(posedge r_clk or posedge r_rst) begin
        if (r_rst)
            r_beat_cnt <= 32'd0;
        else
            r_beat_cnt <= r_beat_cnt + {31'd0, w_pop};
    end
`endif
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: directed and random checks of fifo_rd_stream against a behavioural registered-read FIFO.
module tb_fifo_rd_stream;
    logic        r_clk = 1'b0;
    logic        r_rst = 1'b1;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [31:0] fifo_rd_data;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [31:0] m_data;
`ifdef FIFO_RD_STREAM_STATS_EN
    logic [31:0] beat_cnt;
`endif
    int checks = 0;
    int errors = 0;
    logic [31:0] mem [4096];
    int f_wr = 0;
    int f_rd = 0;

    fifo_rd_stream #(.DATA_W(32)) dut (
        .r_clk(r_clk),
        .r_rst(r_rst),
        .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en),
        .fifo_rd_data(fifo_rd_data),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_data(m_data)
`ifdef FIFO_RD_STREAM_STATS_EN
        ,
        .beat_cnt(beat_cnt)
`endif
    );

    always #5 r_clk = ~r_clk;

    // Registered-read FIFO model, reset together with the DUT.
    assign fifo_empty = (f_rd == f_wr);
    always @(posedge r_clk or posedge r_rst) begin
        if (r_rst) begin
            f_rd         <= f_wr;
            fifo_rd_data <= 32'd0;
        end else if (fifo_rd_en && !fifo_empty) begin
            fifo_rd_data <= mem[f_rd];
            f_rd         <= f_rd + 1;
        end
    end

    task automatic push(input logic [31:0] w);
        mem[f_wr] = w;
        f_wr = f_wr + 1;
    endtask

    task automatic do_reset;
        @(negedge r_clk);
        r_rst   = 1'b1;
        m_ready = 1'b0;
        repeat (2) @(negedge r_clk);
        r_rst = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge r_clk);
        checks++;
        if (m_valid !== 1'b0 || fifo_rd_en !== 1'b0 || m_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: m_valid=%b fifo_rd_en=%b m_data=%h, required 0 0 00000000", m_valid, fifo_rd_en, m_data);
        end
        do_reset();
        @(negedge r_clk);
        checks++;
        if (m_valid !== 1'b0 || fifo_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL after_reset_idle: m_valid=%b fifo_rd_en=%b, required 0 0", m_valid, fifo_rd_en);
        end
    endtask

    // Pushes one word at a negedge (cycle 0) and checks the 2-cycle first-word latency.
    task automatic first_word(input string nm, input logic [31:0] w);
        push(w);
        m_ready = 1'b1;
        #1;
        checks++;
        if (fifo_rd_en !== 1'b1) begin
            errors++;
            $display("FAIL %s_rd_en_c0: fifo_rd_en=%b, required 1", nm, fifo_rd_en);
        end
        @(negedge r_clk);
        checks++;
        if (m_valid !== 1'b0 || fifo_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL %s_c1: m_valid=%b fifo_rd_en=%b, required 0 0", nm, m_valid, fifo_rd_en);
        end
        @(negedge r_clk);
        checks++;
        if (m_valid !== 1'b1 || m_data !== w) begin
            errors++;
            $display("FAIL %s_c2: m_valid=%b m_data=%h, required 1 %h", nm, m_valid, m_data, w);
        end
        @(negedge r_clk);
        checks++;
        if (m_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_c3: m_valid=%b, required 0", nm, m_valid);
        end
    endtask

    task automatic test_single;
        @(negedge r_clk);
        first_word("single", 32'hA5A5_0001);
    endtask

    task automatic test_back_to_back;
        @(negedge r_clk);
        for (int i = 0; i < 16; i++) push(i);
        m_ready = 1'b1;
        @(negedge r_clk);
        checks++;
        if (m_valid !== 1'b0) begin
            errors++;
            $display("FAIL stream_c1: m_valid=%b, required 0", m_valid);
        end
        for (int i = 0; i < 16; i++) begin
            @(negedge r_clk);
            checks++;
            if (m_valid !== 1'b1 || m_data !== 32'(i)) begin
                errors++;
                $display("FAIL stream_beat%0d: m_valid=%b m_data=%h, required 1 %h", i, m_valid, m_data, i);
            end
        end
        @(negedge r_clk);
        checks++;
        if (m_valid !== 1'b0) begin
            errors++;
            $display("FAIL stream_end: m_valid=%b, required 0", m_valid);
        end
    endtask

    task automatic test_backpressure;
        int base;
        int k;
        @(negedge r_clk);
        m_ready = 1'b0;
        base = f_rd;
        for (int i = 0; i < 8; i++) push(i);
        for (int i = 0; i < 10; i++) begin
            @(negedge r_clk);
            if (i >= 2) begin
                checks++;
                if (m_valid !== 1'b1 || m_data !== 32'd0) begin
                    errors++;
                    $display("FAIL bp_hold%0d: m_valid=%b m_data=%h, required 1 00000000", i, m_valid, m_data);
                end
            end
        end
        checks++;
        if (f_rd - base !== 2 || fifo_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL bp_reads: accepted=%0d fifo_rd_en=%b, required 2 0", f_rd - base, fifo_rd_en);
        end
        m_ready = 1'b1;
        #1;
        checks++;
        if (fifo_rd_en !== 1'b1) begin
            errors++;
            $display("FAIL bp_reenable: fifo_rd_en=%b, required 1", fifo_rd_en);
        end
        k = 0;
        for (int c = 0; c < 40 && k < 8; c++) begin
            if (m_valid) begin
                checks++;
                if (m_data !== 32'(k)) begin
                    errors++;
                    $display("FAIL bp_beat%0d: m_data=%h, required %h", k, m_data, k);
                end
                k++;
            end
            @(negedge r_clk);
        end
        checks++;
        if (k !== 8 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain: beats=%0d m_valid=%b, required 8 0", k, m_valid);
        end
    endtask

    task automatic test_random_stall;
        int base;
        int pushed;
        int k;
        int bad;
        @(negedge r_clk);
        base = f_wr;
        pushed = 0;
        k = 0;
        bad = 0;
        for (int c = 0; c < 20000 && k < 1000; c++) begin
            if (pushed < 1000 && $urandom_range(1, 0) == 1) begin
                push($urandom);
                pushed++;
            end
            m_ready = $urandom_range(1, 0) == 1;
            if (int'(dut.r_count) + int'(dut.r_inflight) > 2) bad++;
            if (m_valid && m_ready) begin
                checks++;
                if (m_data !== mem[base + k]) begin
                    errors++;
                    $display("FAIL rand_beat%0d: m_data=%h, required %h", k, m_data, mem[base + k]);
                end
                k++;
            end
            @(negedge r_clk);
        end
        checks++;
        if (k !== 1000 || bad !== 0) begin
            errors++;
            $display("FAIL rand_summary: beats=%0d overfill_cycles=%0d, required 1000 0", k, bad);
        end
    endtask

    task automatic test_reset_mid;
        @(negedge r_clk);
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(32'hBEEF_0000 + i);
        repeat (4) @(negedge r_clk);
        checks++;
        if (m_valid !== 1'b1 || m_data !== 32'hBEEF_0000) begin
            errors++;
            $display("FAIL mid_prefill: m_valid=%b m_data=%h, required 1 beef0000", m_valid, m_data);
        end
        #2 r_rst = 1'b1;
        #1;
        checks++;
        if (m_valid !== 1'b0 || fifo_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: m_valid=%b fifo_rd_en=%b, required 0 0", m_valid, fifo_rd_en);
        end
        @(negedge r_clk);
        r_rst = 1'b0;
        first_word("mid_relaunch", 32'hC0DE_0001);
    endtask

`ifdef FIFO_RD_STREAM_STATS_EN
    task automatic test_stats;
        do_reset();
        checks++;
        if (beat_cnt !== 32'd0) begin
            errors++;
            $display("FAIL stats_reset: beat_cnt=%0d, required 0", beat_cnt);
        end
        for (int i = 0; i < 37; i++) push(i);
        m_ready = 1'b1;
        repeat (45) @(negedge r_clk);
        checks++;
        if (beat_cnt !== 32'd37) begin
            errors++;
            $display("FAIL stats_37: beat_cnt=%0d, required 37", beat_cnt);
        end
        force dut.r_beat_cnt = 32'hFFFF_FFFF;
        @(negedge r_clk);
        release dut.r_beat_cnt;
        push(32'h1234_5678);
        repeat (5) @(negedge r_clk);
        checks++;
        if (beat_cnt !== 32'd0) begin
            errors++;
            $display("FAIL stats_wrap: beat_cnt=%h, required 00000000", beat_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_random_stall();
        test_reset_mid();
`ifdef FIFO_RD_STREAM_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Read-side adapter placed directly downstream of the async FIFO, in its read clock domain. It converts the FIFO's registered-read interface into a valid/ready stream. The FIFO interface is `r_en`/`empty`, with `r_data` arriving one cycle after an accepted read. The block prefetches into a 2-entry output buffer, so it sustains one beat per cycle under continuous `m_ready` and never drops or duplicates a word.

## Interface
- `DATA_W`, default 32: word width; must match the FIFO.
- `r_clk`  in  1  read-domain clock.
- `r_rst`  in  1  reset, asynchronous, active-high.
- `fifo_empty`  in  1  FIFO `empty`.
- `fifo_rd_en`  out  1  FIFO `r_en`.
- `fifo_rd_data`  in  DATA_W  FIFO `r_data`; valid in the cycle after an accepted read.
- `m_valid`  out  1  stream data valid.
- `m_ready`  in  1  stream consumer ready.
- `m_data`  out  DATA_W  stream payload.
- `beat_cnt`  out  32  accepted-beat counter; exists only with `FIFO_RD_STREAM_STATS_EN`.

## Operation
- **Accepted read:** `fifo_rd_en && !fifo_empty` sampled on `r_clk`.
- **`inflight` flop:** registers the accepted-read condition. `inflight=1` means `fifo_rd_data` is valid in the current cycle.
- **Buffer:** 2-entry FIFO of DATA_W words with head/tail pointers and `count` (0..2).
  - Written when `inflight=1`.
  - Popped when `m_valid && m_ready` (`pop`).
- **Outputs:** `m_valid = (count != 0)`; `m_data = buf[head]`. Both are driven from flops and pointer mux only; no combinational path from `fifo_rd_data`.
- **Read issue:** `fifo_rd_en = !r_rst && !fifo_empty && (count + inflight - pop) <= 1`.
  - This is the only combinational path, from `m_ready` to `fifo_rd_en`.
  - It guarantees `count + inflight` never exceeds 2.
- **Capture:** an inflight word is always captured. Capture has priority over nothing: the buffer cannot be full when `inflight=1`.
- **Simultaneous write and pop:** `count` is unchanged; both pointers advance.
- **Pointers:** head and tail are 1 bit each, wrap modulo 2, and reset to 0.
- **Stream hold rule:** once `m_valid=1`, `m_valid` and `m_data` hold until a cycle with `m_ready=1`.
- **Ordering:** words leave in FIFO order, exactly once.
- **`m_ready` independence:** `m_ready` may toggle freely; `m_valid` does not depend on `m_ready`.
- **Reset values:** `m_valid=0`, `m_data='0`, `count=0`, `inflight=0`, pointers 0, `fifo_rd_en=0`, `beat_cnt=0`.
- **Reset mid-operation:**
  - Buffered and inflight words are discarded.
  - The FIFO must be reset in the same domain concurrently, so that no accepted read is lost out of step.

## Timing
- **First-word latency:** `fifo_empty` falls in cycle 0, so `fifo_rd_en=1` in cycle 0. `fifo_rd_data` is valid in cycle 1 and captured at the end of cycle 1. `m_valid=1` from cycle 2.
- **Throughput:** 1 word/cycle with `fifo_empty=0` and `m_ready=1`; steady state is `count=1`, `inflight=1`.
- **Backpressure:**
  - With `m_ready=0`, at most 2 words are held.
  - `fifo_rd_en` drops once `count + inflight = 2`.
  - The first `m_ready=1` cycle re-enables `fifo_rd_en` in that same cycle.
- **Drain:** after `fifo_empty` rises, `m_valid` stays high until the buffer drains.

## Configuration
- **`FIFO_RD_STREAM_STATS_EN` defined:**
  - `beat_cnt` port exists.
  - It increments by 1 on every `pop`, wraps 0xFFFF_FFFF→0, and resets to 0.
- **Undefined:** the port and counter logic are absent; datapath behaviour is identical.

## Test plan
- **Single word:** reset, then FIFO holds 0xA5A5_0001, `m_ready=1`. Expect `fifo_rd_en` cycle 0, `m_valid` cycle 2 with `m_data=0xA5A5_0001` for exactly one cycle, then `m_valid=0`.
- **Streaming:** 16 words 0..15, `m_ready=1` constant. Expect 16 consecutive `m_valid` cycles carrying 0..15 in order, no gaps after the first.
- **Backpressure:** 8 words, `m_ready=0` for 10 cycles, then 1. Expect exactly 2 accepted reads while stalled, `m_data=0` held stable, then values 0..7 in order with no loss or duplication.
- **Random stall:** 1000 random words, random `m_ready` (50%), random FIFO refill. Expect scoreboard match and `count + inflight <= 2` every cycle.
- **Reset mid-stream:** assert `r_rst` asynchronously with 2 words buffered. Expect `m_valid=0` and `fifo_rd_en=0` immediately; after release, normal first-word latency.
- **Stats counter (with `FIFO_RD_STREAM_STATS_EN`):** 37 accepted beats. Expect `beat_cnt=37`. Force the counter to 0xFFFF_FFFF, then one beat. Expect `beat_cnt=0`.
